// File: rtl/rails_pkg.sv
// ============================================================================
// rails_pkg : shared types and defaults for the rails pattern transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

package rails_pkg;

    localparam int DEF_MAX_N   = 10;
    localparam int DEF_DW      = 4;
    localparam int DEF_TIMEOUT = 64;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_TX_SIZE = 3'd2,
        ST_TX_SEQ  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_REPORT  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rails_stack.sv
// ============================================================================
// rails_stack : LIFO station stack, one push or one pop per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module rails_stack
    import rails_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_N,
    parameter int W     = DEF_DW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 top,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH+1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_cw-1:0] r_count;
    logic [c_aw-1:0] w_top_ptr;
    logic [c_aw-1:0] w_wr_ptr;

    assign w_top_ptr = c_aw'(r_count - c_cw'(1));
    assign w_wr_ptr  = c_aw'(r_count);
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cw'(DEPTH));
    assign count     = r_count;
    assign top       = empty ? '0 : r_mem[w_top_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (push && !full) begin
            r_count <= r_count + c_cw'(1);
        end else if (pop && !empty) begin
            r_count <= r_count - c_cw'(1);
        end
    end

    // Storage carries no reset; only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rails_pattern_tx.sv
// ============================================================================
// rails_pattern_tx : builds a rails checker frame from push/pop ops and reports
//                    the checker verdict with error/timeout flags
// Rev 1.0
// ============================================================================
`default_nettype none

module rails_pattern_tx
    import rails_pkg::*;
#(
    parameter int MAX_N   = DEF_MAX_N,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic          op_push,
    input  logic          op_last,
    output logic          chk_reset,
    output logic [DW-1:0] data,
    input  logic          chk_valid,
    input  logic          chk_result,
    output logic          res_valid,
    output logic          res_result,
    output logic          res_err,
    output logic          res_timeout
);

    localparam int            c_aw      = $clog2(MAX_N);
    localparam int            c_tw      = $clog2(TIMEOUT);
    localparam int            c_cw      = $clog2(MAX_N+1);
    localparam logic [DW:0]   c_one_id  = (DW+1)'(1);
    localparam logic [DW:0]   c_max_id  = (DW+1)'(MAX_N);
    localparam logic [c_tw-1:0] c_to_last = c_tw'(TIMEOUT-1);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW:0]     r_next_id;
    logic [DW:0]     r_wptr;
    logic [DW:0]     r_idx;
    logic [c_tw-1:0] r_timer;
    logic            r_err;
    logic [DW-1:0]   r_seq [MAX_N];

    logic [DW:0]     w_size;
    logic            w_fire;
    logic            w_is_push;
    logic            w_push_ok;
    logic            w_stk_push;
    logic            w_stk_pop;
    logic            w_op_err;
    logic            w_drain_done;
    logic            w_size_zero;
    logic            w_seq_done;
    logic            w_to_hit;

    logic [DW-1:0]   w_top;
    logic            w_empty;
    logic            w_full;
    logic [c_cw-1:0] w_count;

    rails_stack #(
        .DEPTH (MAX_N),
        .W     (DW)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (w_stk_push),
        .pop   (w_stk_pop),
        .din   (r_next_id[DW-1:0]),
        .top   (w_top),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    // Frame size is the number of trains that actually entered the station.
    assign w_size       = r_next_id - c_one_id;
    assign w_size_zero  = (w_size == '0);
    assign w_drain_done = (r_state == ST_DRAIN) && (w_count == '0);
    assign w_seq_done   = (r_idx == w_size);
    assign w_to_hit     = (r_timer == c_to_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:    if (w_fire && op_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (w_drain_done) w_state_nxt = w_size_zero ? ST_REPORT : ST_TX_SIZE;
            ST_TX_SIZE: w_state_nxt = ST_TX_SEQ;
            ST_TX_SEQ:  if (w_seq_done) w_state_nxt = ST_WAIT;
            ST_WAIT:    if (chk_valid || w_to_hit) w_state_nxt = ST_REPORT;
            ST_REPORT:  w_state_nxt = ST_LOAD;
            default:    w_state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        op_ready   = (r_state == ST_LOAD);
        w_fire     = op_valid && (r_state == ST_LOAD);
        w_is_push  = (op_push == OP_PUSH);
        w_push_ok  = (r_next_id <= c_max_id) && !w_full;
        w_stk_push = w_fire && w_is_push && w_push_ok;
        w_stk_pop  = (w_fire && !w_is_push && !w_empty)
                   || ((r_state == ST_DRAIN) && (w_count != '0));
        w_op_err   = w_fire && (w_is_push ? !w_push_ok : w_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_id   <= c_one_id;
            r_err       <= 1'b0;
            r_wptr      <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            data        <= '0;
            chk_reset   <= 1'b1;
            res_valid   <= 1'b0;
            res_result  <= 1'b0;
            res_err     <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            if (w_stk_push) begin
                r_next_id <= r_next_id + c_one_id;
            end
            if (w_op_err) begin
                r_err <= 1'b1;
            end
            if (w_stk_pop) begin
                r_wptr <= r_wptr + c_one_id;
            end

            case (r_state)
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        if (w_size_zero) begin
                            res_valid   <= 1'b1;
                            res_result  <= 1'b0;
                            res_err     <= 1'b1;
                            res_timeout <= 1'b0;
                        end else begin
                            // Checker leaves reset together with the size word.
                            data      <= w_size[DW-1:0];
                            chk_reset <= 1'b0;
                        end
                    end
                end
                ST_TX_SIZE: begin
                    data  <= r_seq[0];
                    r_idx <= c_one_id;
                end
                ST_TX_SEQ: begin
                    if (w_seq_done) begin
                        data    <= '0;
                        r_timer <= '0;
                    end else begin
                        data  <= r_seq[r_idx[c_aw-1:0]];
                        r_idx <= r_idx + c_one_id;
                    end
                end
                ST_WAIT: begin
                    if (chk_valid) begin
                        res_valid   <= 1'b1;
                        res_result  <= chk_result;
                        res_err     <= r_err;
                        res_timeout <= 1'b0;
                        chk_reset   <= 1'b1;
                    end else if (w_to_hit) begin
                        res_valid   <= 1'b1;
                        res_result  <= 1'b0;
                        res_err     <= r_err;
                        res_timeout <= 1'b1;
                        chk_reset   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_tw'(1);
                    end
                end
                ST_REPORT: begin
                    res_valid <= 1'b0;
                    chk_reset <= 1'b1;
                    r_next_id <= c_one_id;
                    r_err     <= 1'b0;
                    r_wptr    <= '0;
                    r_idx     <= '0;
                    r_timer   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Departure list: every pop, from an op or from draining, lands here.
    always_ff @(posedge clk) begin
        if (w_stk_pop) begin
            r_seq[r_wptr[c_aw-1:0]] <= w_top;
        end
    end

endmodule

`default_nettype wire
